// File: rtl/imem_loader_if.sv
// Byte-stream input channel and instruction-memory write port of the
// instruction-memory loader. The master side is the loader; the slave side is
// the byte source together with the memory being filled.
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a byte stream MSB-first into 32-bit words,
// writes them sequentially into the CPU instruction memory, and releases the
// CPU's active-low reset once the requested number of words has been written.
// Every output is decoded from registered state and counters only.
module imem_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    imem_loader_if.master     bus,
    output logic              cpu_rst_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   word_cnt_o
);

    // Idle counter wide enough to reach TIMEOUT; one bit when the timeout is off.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] len_sat;
    logic [ADDR_W:0] word_cnt;
    logic [ADDR_W:0] word_cnt_inc;
    logic [1:0]      byte_cnt;
    logic [TW-1:0]   idle_cnt;
    logic [TW-1:0]   idle_cnt_inc;
    logic [31:0]     word_sr;
    logic            take_start;
    logic            accept;

    // Requested lengths beyond the memory depth are clamped so the address never wraps.
    assign len_sat      = (len_i > DEPTH) ? DEPTH : len_i;
    assign word_cnt_inc = word_cnt + (ADDR_W + 1)'(1);
    assign idle_cnt_inc = idle_cnt + TW'(1);
    assign word_cnt_o   = word_cnt;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_next     = state;
        take_start     = 1'b0;
        accept         = 1'b0;
        bus.byte_ready = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = 32'd0;
        bus.mem_wdata  = 32'd0;
        cpu_rst_n_o    = 1'b0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        err_o          = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                done_o      = (state == S_DONE);
                cpu_rst_n_o = (state == S_DONE);
                err_o       = (state == S_ERR);
                if (start_i) begin
                    take_start = 1'b1;
                    state_next = (len_sat == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                bus.byte_ready = 1'b1;
                busy_o         = 1'b1;
                accept         = bus.byte_valid;
                if (accept) begin
                    if (byte_cnt == 2'd3) begin
                        state_next = S_WRITE;
                    end
                end else if ((TIMEOUT != 0) && (idle_cnt_inc == TW'(TIMEOUT))) begin
                    state_next = S_ERR;
                end
            end
            S_WRITE: begin
                busy_o        = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = 32'(word_cnt[ADDR_W-1:0]) << 2;
                bus.mem_wdata = word_sr;
                state_next    = (word_cnt_inc == len_q) ? S_DONE : S_RECV;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Load length, word/byte counters and idle counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q    <= '0;
            word_cnt <= '0;
            byte_cnt <= 2'd0;
            idle_cnt <= '0;
        end else if (take_start) begin
            len_q    <= len_sat;
            word_cnt <= '0;
            byte_cnt <= 2'd0;
            idle_cnt <= '0;
        end else if (state == S_RECV) begin
            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt_inc;
            end
        end else if (state == S_WRITE) begin
            word_cnt <= word_cnt_inc;
            byte_cnt <= 2'd0;
            idle_cnt <= '0;
        end
    end

    // Byte packer: each accepted byte shifts in at the bottom, so the first lands in [31:24].
    always_ff @(posedge clk_i) begin
        if (accept) begin
            word_sr <= {word_sr[23:0], bus.byte_data};
        end
    end

endmodule
